demux1_8_reg: RTL and testbench

- Registered 1-to-8 demultiplexer; the distributing counterpart of the one-hot 8:1 mux.
- Accepts one WIDTH-bit word with a 3-bit binary destination and delivers it to one of 8 output channels.
- Each output channel has a single-entry holding register and a valid/ready handshake.
- Also emits a registered one-hot select code, so downstream one-hot muxes can be steered from the same decode.

---
 rtl/demux1_8_reg_if.sv | 24 ++
 rtl/demux1_8_reg.sv | 83 ++++++++
 tb/tb_demux1_8_reg.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/demux1_8_reg_if.sv
// Handshake bundle for the registered 1-to-8 demultiplexer: one input word
// with a binary destination, eight registered output channels.
interface demux1_8_reg_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0]   in_data;
  logic [2:0]         in_dest;
  logic               in_valid;
  logic               in_ready;
  logic [8*WIDTH-1:0] out_data;
  logic [7:0]         out_valid;
  logic [7:0]         out_ready;
  logic [7:0]         sel_onehot;

  modport master (
    output in_data, in_dest, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel_onehot
  );

  modport slave (
    input  in_data, in_dest, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel_onehot
  );
endinterface

// File: rtl/demux1_8_reg.sv
// Registered 1-to-8 demultiplexer with per-channel single-entry holding registers.
// Optional accept/stall counters are enabled by defining DEMUX1_8_PERF_CNT_EN.
module demux1_8_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  demux1_8_reg_if.slave bus
`ifdef DEMUX1_8_PERF_CNT_EN
  ,
  output logic [15:0] acc_cnt,
  output logic [15:0] stall_cnt
`endif
);

  logic [7:0]         valid_q, valid_d;
  logic [8*WIDTH-1:0] data_q, data_d;
  logic [7:0]         sel_q, sel_d;
  logic [7:0]         dec;
  logic [7:0]         load;
  logic [7:0]         drain;
  logic               ready;
  logic               accept;

  // Readiness only looks at the addressed channel, so a stalled channel
  // never blocks traffic bound for the others.
  always_comb begin
    dec    = 8'h01 << bus.in_dest;
    ready  = !valid_q[bus.in_dest] || bus.out_ready[bus.in_dest];
    accept = bus.in_valid && ready;
    load   = accept ? dec : 8'h00;
    drain  = valid_q & bus.out_ready;
  end

  always_comb begin
    valid_d = (valid_q & ~drain) | load;
    data_d  = data_q;
    sel_d   = load;
    for (int k = 0; k < 8; k++) begin
      if (load[k]) begin
        data_d[k*WIDTH +: WIDTH] = bus.in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 8'h00;
      data_q  <= '0;
      sel_q   <= 8'h00;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = valid_q;
  assign bus.out_data   = data_q;
  assign bus.sel_onehot = sel_q;

`ifdef DEMUX1_8_PERF_CNT_EN
  logic [15:0] acc_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall = bus.in_valid && !ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt_q   <= 16'h0000;
      stall_cnt_q <= 16'h0000;
    end else begin
      if (accept) acc_cnt_q   <= acc_cnt_q + 16'h0001;
      if (stall)  stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign acc_cnt   = acc_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_demux1_8_reg.sv
// Directed self-checking bench for demux1_8_reg with WIDTH=8; counter checks
// are included when DEMUX1_8_PERF_CNT_EN is defined.
module tb_demux1_8_reg;
  localparam int unsigned W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  demux1_8_reg_if #(.WIDTH(W)) bus ();

`ifdef DEMUX1_8_PERF_CNT_EN
  logic [15:0] acc_cnt, stall_cnt;
`endif

  demux1_8_reg #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DEMUX1_8_PERF_CNT_EN
    ,
    .acc_cnt   (acc_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hFF;
    bus.in_dest   = 3'd3;
    bus.out_ready = 8'h00;

    // Reset while driving traffic
    step();
    step();
    chk("rst_out_valid", bus.out_valid, 8'h00);
    chk("rst_sel", bus.sel_onehot, 8'h00);
    chk("rst_out_data", bus.out_data, 64'h0);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    step();

    // Basic route to channel 3
    bus.in_data  = 8'hA5;
    bus.in_dest  = 3'd3;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    chk("route_valid", bus.out_valid, 8'h08);
    chk("route_data3", bus.out_data[31:24], 8'hA5);
    chk("route_sel", bus.sel_onehot, 8'h08);
    step();
    chk("route_sel_clear", bus.sel_onehot, 8'h00);
    chk("route_hold_valid", bus.out_valid, 8'h08);
    chk("route_hold_data", bus.out_data[31:24], 8'hA5);

    // Backpressure isolation
    bus.in_data  = 8'h77;
    bus.in_dest  = 3'd3;
    bus.in_valid = 1'b1;
    #1;
    chk("bp_ready3", bus.in_ready, 1'b0);
    step();
    chk("bp_stall_valid", bus.out_valid, 8'h08);
    chk("bp_stall_data", bus.out_data[31:24], 8'hA5);
    chk("bp_stall_sel", bus.sel_onehot, 8'h00);
    chk("bp_ready3_again", bus.in_ready, 1'b0);
    bus.in_data = 8'h3C;
    bus.in_dest = 3'd5;
    #1;
    chk("bp_ready5", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_valid", bus.out_valid, 8'h28);
    chk("bp_data5", bus.out_data[47:40], 8'h3C);
    chk("bp_sel5", bus.sel_onehot, 8'h20);

    // Drain both; slices keep last value
    bus.out_ready = 8'hFF;
    step();
    chk("drain_valid", bus.out_valid, 8'h00);
    chk("drain_data3_kept", bus.out_data[31:24], 8'hA5);

    // Streaming into channel 0 with no bubble
    bus.in_dest  = 3'd0;
    bus.in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_data = 8'(i);
      step();
      chk("stream_data0", bus.out_data[7:0], 64'(i));
      chk("stream_valid0", bus.out_valid[0], 1'b1);
    end
    bus.in_valid = 1'b0;
    step();
    chk("stream_end_valid", bus.out_valid, 8'h00);

    // Load/drain collision on channel 2
    bus.out_ready = 8'h00;
    bus.in_dest   = 3'd2;
    bus.in_data   = 8'h11;
    bus.in_valid  = 1'b1;
    step();
    chk("coll_pre_data", bus.out_data[23:16], 8'h11);
    bus.out_ready = 8'h04;
    bus.in_data   = 8'h22;
    #1;
    chk("coll_ready", bus.in_ready, 1'b1);
    step();
    bus.in_valid = 1'b0;
    chk("coll_data", bus.out_data[23:16], 8'h22);
    chk("coll_valid", bus.out_valid, 8'h04);
    chk("coll_sel", bus.sel_onehot, 8'h04);
    step();
    chk("coll_drained", bus.out_valid, 8'h00);

    // Mid-operation reset with channels 1 and 6 full
    bus.out_ready = 8'h00;
    bus.in_valid  = 1'b1;
    bus.in_dest   = 3'd1;
    bus.in_data   = 8'h61;
    step();
    bus.in_dest = 3'd6;
    bus.in_data = 8'h66;
    step();
    bus.in_valid = 1'b0;
    chk("mid_pre_valid", bus.out_valid, 8'h42);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", bus.out_valid, 8'h00);
    chk("mid_rst_sel", bus.sel_onehot, 8'h00);
    chk("mid_rst_data", bus.out_data, 64'h0);
`ifdef DEMUX1_8_PERF_CNT_EN
    chk("mid_rst_acc", acc_cnt, 16'd0);
    chk("mid_rst_stall", stall_cnt, 16'd0);
`endif

    // Three accepts then two stall cycles on channel 4
    bus.out_ready = 8'hFF;
    bus.in_dest   = 3'd4;
    bus.in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.in_data = 8'(i);
      step();
    end
    bus.out_ready = 8'h00;
    bus.in_data   = 8'h99;
    step();
    step();
    bus.in_valid = 1'b0;
    chk("cnt_valid", bus.out_valid, 8'h10);
    chk("cnt_data4", bus.out_data[39:32], 8'h03);
    chk("cnt_sel", bus.sel_onehot, 8'h00);
`ifdef DEMUX1_8_PERF_CNT_EN
    chk("cnt_acc", acc_cnt, 16'd3);
    chk("cnt_stall", stall_cnt, 16'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
